// File: rtl/multdiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide controller.
//   WIDTH      operand/result width (matches the shared ALU)
//   ITERS      iterations per multiply or divide
//   COUNT_W    iteration counter width
//   ALU_OP_*   opcodes driven to the shared ALU
//   mdState    controller state encoding
package multdiv_pkg;

  localparam int WIDTH   = 32;
  localparam int ITERS   = 32;
  localparam int COUNT_W = 6;

  localparam logic [4:0] ALU_OP_ADD = 5'b00000;
  localparam logic [4:0] ALU_OP_SUB = 5'b00001;

  typedef enum logic [2:0] {
    IDLE,
    MUL_ITER,
    DIV_ITER,
    DIV_ZERO,
    DONE
  } mdState;

endpackage

// File: rtl/negate32.sv
// Conditional two's-complement negate.
//   value   input word
//   negate  1: result = -value, 0: result = value
//   result  output word
module negate32
  import multdiv_pkg::*;
(
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/multdiv_seq.sv
// Multi-cycle signed 32-bit multiply (radix-2 Booth) / divide (restoring, on
// magnitudes) controller. Issues one add or subtract per cycle to the shared
// ALU and owns its operand/opcode mux while busy.
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   data_operandA / data_operandB   multiplicand/dividend, multiplier/divisor (sampled on start)
//   ctrl_MULT / ctrl_DIV            one-cycle start pulses (MULT wins; any start aborts a running op)
//   alu_operandA/B, alu_opcode      to the shared ALU
//   alu_result, alu_overflow        from the shared ALU
//   data_result, data_exception     product low word / quotient and overflow flag, held until next start
//   data_resultRDY                  one-cycle done pulse
//   busy                            high from the cycle after start through the RDY cycle
// Optional build macro MULTDIV_ZERO_FAST_EN: multiply with a zero operand, or
// divide of zero by a non-zero divisor, finishes in two cycles with result 0.
module multdiv_seq
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  mdState               state, nextState;
  logic [COUNT_W-1:0]   count;
  // hiReg/loReg hold Booth {hi,lo} for multiply and {R,Q} for divide;
  // mReg holds the multiplicand or the divisor magnitude.
  logic [WIDTH-1:0]     hiReg, loReg, mReg;
  logic                 q1Reg, signReg, skipExc;

  logic                 start, lastIter, divByZero, fastZero;
  logic [WIDTH-1:0]     absA, absB, quotFix;
  logic [WIDTH-1:0]     mulHi, mulLo, rShift, divR, divQ;
  logic                 borrow;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign lastIter  = (count == COUNT_W'(ITERS - 1));
  assign divByZero = (data_operandB == '0);

`ifdef MULTDIV_ZERO_FAST_EN
  assign fastZero = ctrl_MULT ? (data_operandA == '0 || data_operandB == '0)
                              : (data_operandA == '0 && !divByZero);
`else
  assign fastZero = 1'b0;
`endif

  negate32 u_absA (.value(data_operandA), .negate(data_operandA[WIDTH-1]), .result(absA));
  negate32 u_absB (.value(data_operandB), .negate(data_operandB[WIDTH-1]), .result(absB));
  negate32 u_quot (.value(divQ),          .negate(signReg),                .result(quotFix));

  // Booth step: the ALU sum can need 33 bits, so the true sign to shift in
  // is the result MSB corrected by the overflow flag.
  assign mulHi = {alu_result[WIDTH-1] ^ alu_overflow, alu_result[WIDTH-1:1]};
  assign mulLo = {alu_result[0], loReg[WIDTH-1:1]};

  // Restoring step: unsigned compare of R_shifted against |B| using the
  // 32-bit difference; when the MSBs differ the larger operand is known directly.
  assign rShift = {hiReg[WIDTH-2:0], loReg[WIDTH-1]};
  assign borrow = (rShift[WIDTH-1] != mReg[WIDTH-1]) ? mReg[WIDTH-1] : alu_result[WIDTH-1];
  assign divR   = borrow ? rShift : alu_result;
  assign divQ   = {loReg[WIDTH-2:0], ~borrow};

  assign busy           = (state != IDLE);
  assign data_resultRDY = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    nextState = state;
    case (state)
      MUL_ITER, DIV_ITER: if (lastIter) nextState = DONE;
      DIV_ZERO:           nextState = DONE;
      default:            nextState = IDLE;
    endcase
    // A start pulse overrides whatever is running.
    if (ctrl_MULT)     nextState = fastZero ? DIV_ZERO : MUL_ITER;
    else if (ctrl_DIV) nextState = (divByZero || fastZero) ? DIV_ZERO : DIV_ITER;
  end

  always_comb begin
    alu_operandA = '0;
    alu_operandB = '0;
    alu_opcode   = ALU_OP_ADD;
    case (state)
      MUL_ITER: begin
        alu_operandA = hiReg;
        case ({loReg[0], q1Reg})
          2'b01:   alu_operandB = mReg;
          2'b10: begin
            alu_operandB = mReg;
            alu_opcode   = ALU_OP_SUB;
          end
          default: alu_operandB = '0;
        endcase
      end
      DIV_ITER: begin
        alu_operandA = rShift;
        alu_operandB = mReg;
        alu_opcode   = ALU_OP_SUB;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      hiReg          <= '0;
      loReg          <= '0;
      mReg           <= '0;
      q1Reg          <= 1'b0;
      signReg        <= 1'b0;
      skipExc        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      count          <= '0;
      hiReg          <= '0;
      q1Reg          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      if (ctrl_MULT) begin
        loReg   <= data_operandB;
        mReg    <= data_operandA;
        signReg <= 1'b0;
        skipExc <= 1'b0;
      end else begin
        loReg   <= absA;
        mReg    <= absB;
        signReg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        skipExc <= divByZero;
      end
    end else begin
      case (state)
        MUL_ITER: begin
          count <= count + 1'b1;
          hiReg <= mulHi;
          loReg <= mulLo;
          q1Reg <= loReg[0];
          if (lastIter) begin
            data_result    <= mulLo;
            data_exception <= (mulHi != {WIDTH{mulLo[WIDTH-1]}});
          end
        end
        DIV_ITER: begin
          count <= count + 1'b1;
          hiReg <= divR;
          loReg <= divQ;
          if (lastIter) begin
            data_result    <= quotFix;
            // Only -2^31 / -1 leaves a positive quotient that does not fit.
            data_exception <= ~signReg & divQ[WIDTH-1];
          end
        end
        // Short path: result stays 0; exception only for a zero divisor.
        DIV_ZERO: data_exception <= skipExc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: shared-ALU model, directed cases,
// abort/reset scenarios and randomized operations against a plain-arithmetic
// reference model.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] alu_operandA, alu_operandB, alu_result;
  logic [4:0]  alu_opcode;
  logic        alu_overflow;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks   = 0;
  int failures = 0;

  multdiv_seq dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .alu_operandA  (alu_operandA),
    .alu_operandB  (alu_operandB),
    .alu_opcode    (alu_opcode),
    .alu_result    (alu_result),
    .alu_overflow  (alu_overflow),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Shared ALU: add or subtract with signed overflow flag.
  always_comb begin
    if (alu_opcode == 5'b00001) begin
      alu_result   = alu_operandA - alu_operandB;
      alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end else begin
      alu_result   = alu_operandA + alu_operandB;
      alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: signed 64-bit product / truncating signed quotient.
  task automatic refOp(input bit isMult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc);
    longint prod;
    int     lo;
    int     quo;
    if (isMult) begin
      prod = longint'(signed'(a)) * longint'(signed'(b));
      lo   = int'(prod[31:0]);
      res  = prod[31:0];
      exc  = (prod != longint'(lo));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      quo = signed'(a) / signed'(b);
      res = quo;
      exc = 1'b0;
    end
  endtask

  function automatic int expLatency(input bit isMult, input logic [31:0] a, input logic [31:0] b);
    if (!isMult && b == 32'd0) return 2;
`ifdef MULTDIV_ZERO_FAST_EN
    if (isMult && (a == 32'd0 || b == 32'd0)) return 2;
    if (!isMult && a == 32'd0) return 2;
`endif
    return 33;
  endfunction

  // Called at a negedge: drives a one-cycle start pulse; returns at the
  // negedge of the first busy cycle with operands scrambled.
  task automatic pulse(input bit doMult, input bit doDiv, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = doMult;
    ctrl_DIV      = doDiv;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic waitDone(input string tag, input int expLat, input logic [31:0] expRes, input logic expExc);
    int lat = 1;
    bit busyDrop = 1'b0;
    while (!data_resultRDY && lat < 100) begin
      if (!busy) busyDrop = 1'b1;
      @(negedge clock);
      lat++;
    end
    check({tag, ".latency"},  lat,            expLat);
    check({tag, ".busyRun"},  busyDrop,       1'b0);
    check({tag, ".busyRdy"},  busy,           1'b1);
    check({tag, ".result"},   data_result,    expRes);
    check({tag, ".exc"},      data_exception, expExc);
    @(negedge clock);
    check({tag, ".rdyPulse"}, data_resultRDY, 1'b0);
    check({tag, ".idle"},     busy,           1'b0);
    check({tag, ".hold"},     data_result,    expRes);
    check({tag, ".holdExc"},  data_exception, expExc);
  endtask

  task automatic runOp(input string tag, input bit isMult, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic        exc;
    refOp(isMult, a, b, res, exc);
    pulse(isMult, !isMult, a, b);
    waitDone(tag, expLatency(isMult, a, b), res, exc);
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, ".result"}, data_result,    32'd0);
    check({tag, ".exc"},    data_exception, 1'b0);
    check({tag, ".rdy"},    data_resultRDY, 1'b0);
    check({tag, ".busy"},   busy,           1'b0);
    check({tag, ".aluA"},   alu_operandA,   32'd0);
    check({tag, ".aluB"},   alu_operandB,   32'd0);
    check({tag, ".aluOp"},  {27'd0, alu_opcode}, 32'd0);
  endtask

  initial begin
    bit          isMult;
    bit          sawRdy;
    logic [31:0] a, b;

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(negedge clock);
    checkIdleOutputs("postReset");

    // Directed cases.
    runOp("mul7xm3",     1'b1, 32'd7,          32'hFFFF_FFFD);
    runOp("mulOvf",      1'b1, 32'h0001_0000,  32'h0001_0000);
    runOp("mulMinXm1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF);
    runOp("mulMinXMin",  1'b1, 32'h8000_0000,  32'h8000_0000);
    runOp("divM100by7",  1'b0, 32'hFFFF_FF9C,  32'd7);
    runOp("divMinBy1",   1'b0, 32'h8000_0000,  32'd1);
    runOp("divByZero",   1'b0, 32'd1234,       32'd0);
    runOp("divMinByM1",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF);
    runOp("divByMin",    1'b0, 32'h8000_0000,  32'h8000_0000);
    runOp("mulZeroA",    1'b1, 32'd0,          32'd9);
    runOp("divZeroA",    1'b0, 32'd0,          32'hFFFF_FFF9);

    // Both start pulses together: multiply wins.
    pulse(1'b1, 1'b1, 32'd6, 32'hFFFF_FFFE);
    waitDone("bothStart", 33, 32'hFFFF_FFF4, 1'b0);

    // Abort a multiply with a divide pulse at N+10.
    pulse(1'b1, 1'b0, 32'd7, 32'd5);
    sawRdy = 1'b0;
    repeat (9) begin
      if (data_resultRDY) sawRdy = 1'b1;
      @(negedge clock);
    end
    pulse(1'b0, 1'b1, 32'd20, 32'd4);
    check("abort.noMulRdy", sawRdy, 1'b0);
    waitDone("abort", 33, 32'd5, 1'b0);

    // Reset at N+5 during a divide.
    pulse(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkIdleOutputs("midReset");
    sawRdy = 1'b0;
    repeat (40) begin
      if (data_resultRDY || busy) sawRdy = 1'b1;
      @(negedge clock);
    end
    check("midReset.quiet", sawRdy, 1'b0);

    // Randomized operations with a bias toward corner operands.
    for (int i = 0; i < 40; i++) begin
      isMult = ($urandom_range(0, 1) == 1);
      a      = $urandom;
      b      = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'd0;
        2: b = 32'($urandom_range(0, 16)) - 32'd8;
        3: a = 32'h8000_0000;
        4: begin
          a = 32'($urandom_range(0, 2000)) - 32'd1000;
          b = 32'($urandom_range(0, 2000)) - 32'd1000;
        end
        default: ;
      endcase
      runOp($sformatf("rnd%0d", i), isMult, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
